// File: rtl/pedometer_pkg.sv
// Shared definitions for the pedometer step-detection path.
// Holds the peak-tracker state encoding, the data/parameter/count widths
// and the register-file address that receives the running step total.
package pedometer_pkg;

    localparam int SAMPLE_W  = 8;   // acceleration magnitude width
    localparam int PARAM_W   = 8;   // thresholds, intervals, run lengths
    localparam int COUNT_W   = 16;  // total confirmed steps
    localparam int WB_ADDR_W = 3;   // weight register file address width

    localparam logic [WB_ADDR_W-1:0] TOTAL_STEPS_ADDR = 3'd6;
    localparam logic [PARAM_W-1:0]   PARAM_MAX        = '1;

    // Peak tracker: IDLE waits for a rise above theta1, HIGH measures the
    // peak width, FALL waits for the valley below theta2.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        FALL = 2'd2
    } peak_state_t;

endpackage

// File: rtl/step_detector_if.sv
// Sample stream in, totalSteps write-back out.
//   sample_valid / sample : one unsigned magnitude per qualified cycle,
//                           no backpressure
//   wb_valid / wb_addr /   : one-cycle write of min(step_count,255) toward
//   wb_data                  the weight register file
// master = sample producer / write-back consumer, slave = step_detector.
interface step_detector_if;
    import pedometer_pkg::*;

    logic                 sample_valid;
    logic [SAMPLE_W-1:0]  sample;
    logic                 wb_valid;
    logic [WB_ADDR_W-1:0] wb_addr;
    logic [SAMPLE_W-1:0]  wb_data;

    modport master (
        output sample_valid, sample,
        input  wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  sample_valid, sample,
        output wb_valid, wb_addr, wb_data
    );

endinterface

// File: rtl/interval_timer.sv
// Counts valid samples since the last accepted step candidate and flags
// the inter-step timeout.
//   clk, reset : clock and asynchronous active-high reset
//   advance    : a valid sample is consumed this cycle
//   restart    : the current sample is an accepted candidate (count -> 0)
//   clear      : counts are being cleared (count -> 255, "long ago")
//   beta2      : maximum inter-step interval
//   interval   : registered count, excluding the current sample
//   timeout    : this sample pushes the count beyond beta2
module interval_timer
    import pedometer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               restart,
    input  logic               clear,
    input  logic [PARAM_W-1:0] beta2,
    output logic [PARAM_W-1:0] interval,
    output logic               timeout
);

    logic [PARAM_W-1:0] interval_d;
    logic [PARAM_W-1:0] interval_q;

    function automatic logic [PARAM_W-1:0] sat_inc(input logic [PARAM_W-1:0] v);
        return (v == PARAM_MAX) ? v : v + PARAM_W'(1);
    endfunction

    always_comb begin
        interval_d = interval_q;
        timeout    = 1'b0;
        if (clear) begin
            interval_d = PARAM_MAX;
        end else if (advance) begin
            if (restart) begin
                interval_d = '0;
            end else begin
                interval_d = sat_inc(interval_q);
                // Level check: once saturated above beta2 this keeps firing,
                // which only re-clears an already-empty run.
                timeout    = (interval_d > beta2);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interval_q <= PARAM_MAX;
        end else begin
            interval_q <= interval_d;
        end
    end

    assign interval = interval_q;

endmodule

// File: rtl/step_detector.sv
// Pedometer step detector.
// Tracks acceleration peaks (rise above theta1 for at least alpha2 samples,
// then fall below theta2), filters candidates by inter-step interval
// (beta1..beta2), and only counts steps once a run of alpha1 regular
// candidates confirms walking; the confirming candidate credits the whole
// run at once. Each change of the total is written back to the weight
// register file.
//   clk, reset     : clock and asynchronous active-high reset
//   bus (slave)    : sample_valid/sample in, wb_valid/wb_addr/wb_data out
//   theta1, theta2 : peak and valley thresholds
//   beta1, beta2   : minimum and maximum inter-step interval (valid samples)
//   alpha1, alpha2 : confirming run length and minimum peak width
//   clear_count    : synchronous clear of count, run and peak tracker
//   step_pulse     : one cycle per accepted candidate that changed the count
//   step_count     : total confirmed steps (saturating)
//   walking        : a confirmed run is active
module step_detector
    import pedometer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    step_detector_if.slave     bus,
    input  logic [PARAM_W-1:0] theta1,
    input  logic [PARAM_W-1:0] theta2,
    input  logic [PARAM_W-1:0] beta1,
    input  logic [PARAM_W-1:0] beta2,
    input  logic [PARAM_W-1:0] alpha1,
    input  logic [PARAM_W-1:0] alpha2,
    input  logic               clear_count,
    output logic               step_pulse,
    output logic [COUNT_W-1:0] step_count,
    output logic               walking
);

    peak_state_t          state_d,      state_q;
    logic [PARAM_W-1:0]   width_d,      width_q;
    logic [PARAM_W-1:0]   run_d,        run_q;
    logic [COUNT_W-1:0]   step_count_d, step_count_q;
    logic                 walking_d,    walking_q;
    logic                 step_pulse_d, step_pulse_q;
    logic                 wb_valid_d,   wb_valid_q;
    logic [WB_ADDR_W-1:0] wb_addr_d,    wb_addr_q;
    logic [SAMPLE_W-1:0]  wb_data_d,    wb_data_q;

    logic                 candidate;
    logic                 accept;
    logic                 timeout;
    logic [PARAM_W-1:0]   interval;
    logic [PARAM_W-1:0]   alpha1_eff;

    function automatic logic [PARAM_W-1:0] sat_inc(input logic [PARAM_W-1:0] v);
        return (v == PARAM_MAX) ? v : v + PARAM_W'(1);
    endfunction

    function automatic logic [COUNT_W-1:0] sat_add_count(input logic [COUNT_W-1:0] a,
                                                         input logic [PARAM_W-1:0] b);
        logic [COUNT_W:0] sum;
        sum = {1'b0, a} + {{(COUNT_W + 1 - PARAM_W){1'b0}}, b};
        return sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
    endfunction

    function automatic logic [SAMPLE_W-1:0] clip_wb(input logic [COUNT_W-1:0] v);
        return (v > COUNT_W'(255)) ? {SAMPLE_W{1'b1}} : v[SAMPLE_W-1:0];
    endfunction

    // Peak tracker; every transition is qualified by sample_valid.
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        candidate = 1'b0;
        if (bus.sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.sample > theta1) begin
                        state_d = HIGH;
                        width_d = PARAM_W'(1);
                    end
                end
                HIGH: begin
                    if (bus.sample > theta1) begin
                        width_d = sat_inc(width_q);
                    end else if (width_q >= alpha2) begin
                        state_d = FALL;
                    end else begin
                        state_d = IDLE;  // too narrow to be a step
                    end
                end
                FALL: begin
                    if (bus.sample < theta2) begin
                        candidate = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (clear_count) begin
            state_d = IDLE;
            width_d = '0;
        end
    end

    // A candidate arriving too soon after the previous accepted one is
    // dropped; clear_count overrides any candidate in the same sample.
    assign accept     = candidate && (interval >= beta1) && !clear_count;
    assign alpha1_eff = (alpha1 == '0) ? PARAM_W'(1) : alpha1;

    interval_timer u_interval_timer (
        .clk      (clk),
        .reset    (reset),
        .advance  (bus.sample_valid),
        .restart  (accept),
        .clear    (clear_count),
        .beta2    (beta2),
        .interval (interval),
        .timeout  (timeout)
    );

    // Run tracking and step accounting.
    always_comb begin
        run_d        = run_q;
        walking_d    = walking_q;
        step_count_d = step_count_q;
        if (clear_count) begin
            run_d        = '0;
            walking_d    = 1'b0;
            step_count_d = '0;
        end else if (accept) begin
            // A gap longer than beta2 means this candidate starts a new run.
            if ((interval > beta2) || (run_q == '0)) begin
                run_d = PARAM_W'(1);
            end else begin
                run_d = sat_inc(run_q);
            end
            if (run_d == alpha1_eff) begin
                // Confirmation credits the steps of the whole qualifying run.
                step_count_d = sat_add_count(step_count_q, alpha1_eff);
                walking_d    = 1'b1;
            end else if (run_d > alpha1_eff) begin
                step_count_d = sat_add_count(step_count_q, PARAM_W'(1));
                walking_d    = 1'b1;
            end
        end else if (timeout) begin
            run_d     = '0;
            walking_d = 1'b0;
        end

        // Write-back only on a real count change, so a saturated total
        // stays quiet and a clear never writes.
        step_pulse_d = !clear_count && (step_count_d != step_count_q);
        wb_valid_d   = step_pulse_d;
        wb_addr_d    = step_pulse_d ? TOTAL_STEPS_ADDR : '0;
        wb_data_d    = step_pulse_d ? clip_wb(step_count_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            width_q      <= '0;
            run_q        <= '0;
            step_count_q <= '0;
            walking_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            run_q        <= run_d;
            step_count_q <= step_count_d;
            walking_q    <= walking_d;
            step_pulse_q <= step_pulse_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign step_pulse   = step_pulse_q;
    assign step_count   = step_count_q;
    assign walking      = walking_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_step_detector.sv
// Directed bench for step_detector. Each driven sample pushes its expected
// outputs onto a scoreboard queue; the entry is popped and compared once the
// DUT has registered that sample.
module tb_step_detector;
    import pedometer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] theta1, theta2, beta1, beta2, alpha1, alpha2;
    logic       clear_count;
    logic       step_pulse;
    logic [15:0] step_count;
    logic       walking;

    step_detector_if bus_if ();

    step_detector dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .theta1      (theta1),
        .theta2      (theta2),
        .beta1       (beta1),
        .beta2       (beta2),
        .alpha1      (alpha1),
        .alpha2      (alpha2),
        .clear_count (clear_count),
        .step_pulse  (step_pulse),
        .step_count  (step_count),
        .walking     (walking)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pulse;
        logic [15:0] count;
        logic        walk;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_count;
    logic        exp_walk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, "_pulse"},    16'(step_pulse),     16'(e.pulse));
        check({tag, "_count"},    step_count,          e.count);
        check({tag, "_walking"},  16'(walking),        16'(e.walk));
        check({tag, "_wb_valid"}, 16'(bus_if.wb_valid), 16'(e.pulse));
        check({tag, "_wb_addr"},  16'(bus_if.wb_addr),  e.pulse ? 16'd6 : 16'd0);
        check({tag, "_wb_data"},  16'(bus_if.wb_data),
              e.pulse ? ((e.count > 16'd255) ? 16'd255 : {8'd0, e.count[7:0]}) : 16'd0);
    endtask

    // One valid sample; expectations come from exp_count/exp_walk.
    task automatic drive(input logic [7:0] s, input logic exp_pulse, input logic clr);
        exp_t e;
        bus_if.sample       = s;
        bus_if.sample_valid = 1'b1;
        clear_count         = clr;
        e.pulse = exp_pulse;
        e.count = exp_count;
        e.walk  = exp_walk;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus_if.sample_valid = 1'b0;
        clear_count         = 1'b0;
        compare_front("sample");
    endtask

    // Peak of width 2 followed by a valley; the final sample is the candidate.
    task automatic peak(input logic pulse, input logic [15:0] cnt_after,
                        input logic walk_after, input logic clr);
        drive(8'd120, 1'b0, 1'b0);
        drive(8'd130, 1'b0, 1'b0);
        drive(8'd90,  1'b0, 1'b0);
        exp_count = cnt_after;
        exp_walk  = walk_after;
        drive(8'd40, pulse, clr);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(8'd40, 1'b0, 1'b0);
    endtask

    // Cycles without sample_valid carrying a large value that must be ignored.
    task automatic idle(input int n);
        bus_if.sample       = 8'd200;
        bus_if.sample_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_pulse", 16'(step_pulse), 16'd0);
            check("idle_count", step_count, exp_count);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        clear_count         = 1'b0;
        bus_if.sample_valid = 1'b0;
        bus_if.sample       = 8'd0;
        theta1 = 8'd100; theta2 = 8'd50;
        beta1  = 8'd3;   beta2  = 8'd20;
        alpha1 = 8'd2;   alpha2 = 8'd2;
        exp_count = 16'd0;
        exp_walk  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pulse",    16'(step_pulse),      16'd0);
        check("rst_count",    step_count,           16'd0);
        check("rst_walking",  16'(walking),         16'd0);
        check("rst_wb_valid", 16'(bus_if.wb_valid), 16'd0);
        check("rst_wb_addr",  16'(bus_if.wb_addr),  16'd0);
        check("rst_wb_data",  16'(bus_if.wb_data),  16'd0);
        reset = 1'b0;

        // Confirmation: first burst starts the run, second confirms two steps.
        drive(8'd40, 1'b0, 1'b0);
        peak(1'b0, 16'd0, 1'b0, 1'b0);
        quiet(4);
        drive(8'd40, 1'b0, 1'b0);
        peak(1'b1, 16'd2, 1'b1, 1'b0);
        idle(2);

        // Narrow peak (width 1) yields nothing; then a regular step adds one.
        drive(8'd40,  1'b0, 1'b0);
        drive(8'd120, 1'b0, 1'b0);
        drive(8'd40,  1'b0, 1'b0);
        quiet(2);
        peak(1'b1, 16'd3, 1'b1, 1'b0);

        // Too fast: with alpha2=2 the shortest peak lands at interval 3, so
        // narrow alpha2 to place the candidate at interval 2.
        alpha2 = 8'd1;
        drive(8'd120, 1'b0, 1'b0);
        drive(8'd40,  1'b0, 1'b0);
        drive(8'd40,  1'b0, 1'b0);
        alpha2 = 8'd2;
        quiet(2);
        peak(1'b1, 16'd4, 1'b1, 1'b0);

        // Timeout: invalid cycles do not advance the interval.
        quiet(10);
        idle(3);
        quiet(10);
        exp_walk = 1'b0;
        drive(8'd40, 1'b0, 1'b0);
        peak(1'b0, 16'd4, 1'b0, 1'b0);
        quiet(3);
        peak(1'b1, 16'd6, 1'b1, 1'b0);

        // Clear on an accepting sample wins over the candidate.
        quiet(3);
        peak(1'b0, 16'd0, 1'b0, 1'b1);
        peak(1'b0, 16'd0, 1'b0, 1'b0);
        quiet(3);
        peak(1'b1, 16'd2, 1'b1, 1'b0);

        // Asynchronous reset mid-peak discards the peak in progress.
        quiet(3);
        drive(8'd120, 1'b0, 1'b0);
        drive(8'd130, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pulse",    16'(step_pulse),      16'd0);
        check("arst_count",    step_count,           16'd0);
        check("arst_walking",  16'(walking),         16'd0);
        check("arst_wb_valid", 16'(bus_if.wb_valid), 16'd0);
        check("arst_wb_addr",  16'(bus_if.wb_addr),  16'd0);
        check("arst_wb_data",  16'(bus_if.wb_data),  16'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_count = 16'd0;
        exp_walk  = 1'b0;
        drive(8'd90, 1'b0, 1'b0);
        drive(8'd40, 1'b0, 1'b0);
        peak(1'b0, 16'd0, 1'b0, 1'b0);
        quiet(3);
        peak(1'b1, 16'd2, 1'b1, 1'b0);

        // Long run with alpha1=200: confirmation credits 200, then +1 per
        // step; write-back data clips at 255 once the total passes it.
        alpha1    = 8'd200;
        exp_count = 16'd0;
        exp_walk  = 1'b0;
        drive(8'd40, 1'b0, 1'b1);
        for (int k = 1; k <= 260; k++) begin
            if (k < 200) peak(1'b0, 16'd0, 1'b0, 1'b0);
            else         peak(1'b1, 16'(k), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/step_detector.md
STEP_DETECTOR -- requirements
Module: step_detector

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port sample_valid, input, 1 bit: sample qualifies this cycle; no backpressure.
REQ-004 SHALL have port sample, input, 8 bits: unsigned acceleration magnitude.
REQ-005 SHALL have ports theta1 and theta2, input, 8 bits each: peak threshold and valley threshold.
REQ-006 SHALL have ports beta1 and beta2, input, 8 bits each: minimum and maximum inter-step interval, in valid samples.
REQ-007 SHALL have ports alpha1 and alpha2, input, 8 bits each: run length that confirms walking, and minimum peak width in samples.
REQ-008 SHALL have port clear_count, input, 1 bit: synchronous clear of counts and run state.
REQ-009 SHALL have port step_pulse, output, 1 bit: one-cycle pulse per accepted counted candidate.
REQ-010 SHALL have port step_count, output, 16 bits: total confirmed steps.
REQ-011 SHALL have port walking, output, 1 bit: high while a confirmed run is active.
REQ-012 SHALL have ports wb_valid (1 bit), wb_addr (3 bits) and wb_data (8 bits), all outputs: totalSteps write-back toward the weight register file.

Function
REQ-013 SHALL ignore all sample-driven state changes in cycles where sample_valid=0.
REQ-014 SHALL use FSM states IDLE, HIGH and FALL, applying all transitions on valid samples only.
REQ-015 SHALL move IDLE->HIGH when sample>theta1, setting width=1.
REQ-016 SHALL, in HIGH, increment width (saturating at 255) while sample>theta1.
REQ-017 SHALL, in HIGH when sample<=theta1, go to FALL if width>=alpha2, else go to IDLE with no candidate.
REQ-018 SHALL, in FALL when sample<theta2, raise a candidate and go to IDLE; otherwise it stays in FALL.
REQ-019 SHALL keep interval, an 8-bit count of valid samples since the last accepted candidate, excluding the current sample, saturating at 255.
REQ-020 SHALL reject a candidate with interval<beta1, leaving run, count and interval unchanged except for the normal interval increment.
REQ-021 SHALL accept every other candidate, clearing interval to 0 and setting run=1 if interval>beta2 or run==0, else run=run+1 (saturating at 255).
REQ-022 SHALL use an effective alpha1 of 1 when alpha1 is 0.
REQ-023 SHALL, when an accepted candidate makes run equal to effective alpha1, add alpha1 to step_count and set walking=1; when run exceeds it, add 1.
REQ-024 SHALL saturate step_count at 16'hFFFF.
REQ-025 SHALL, when interval increments past beta2, clear run to 0 and walking to 0.
REQ-026 SHALL, on clear_count=1, zero step_count, run and walking, set interval=255 and force IDLE, with priority over a simultaneous candidate.
REQ-027 SHALL assert step_pulse, wb_valid, wb_addr=3'd6 and wb_data=min(step_count,255) registered, one cycle after the accepting sample edge, for one cycle only, only when step_count changes.
REQ-028 SHALL apply threshold and parameter input changes on the next valid sample, with no internal latching.

Reset
REQ-029 SHALL, on reset, force IDLE, width=0, run=0, interval=255, step_count=0, walking=0, step_pulse=0, wb_valid=0, wb_addr=0 and wb_data=0.
REQ-030 SHALL let reset asserted mid-peak discard the in-progress candidate, with no write-back emitted.

Structure
REQ-031 SHALL take the state enum, TOTAL_STEPS_ADDR=3'd6 and the width constants from shared package pedometer_pkg.
REQ-032 SHALL implement the interval count and beta2 timeout in one sub-module, interval_timer; all other logic is inline.

Verification
Common parameters for REQ-033 to REQ-037: theta1=100, theta2=50, beta1=3, beta2=20, alpha1=2, alpha2=2.
REQ-033 SHALL verify reset: assert reset mid-peak -> all outputs 0 and next candidate starts run=1 (interval=255).
REQ-034 SHALL verify confirmation: burst 40,120,130,90,40, then 4 samples of 40, then the burst again -> first burst gives no count; second gives step_count=2, walking=1, step_pulse one cycle, wb_addr=6, wb_data=2.
REQ-035 SHALL verify narrow-peak rejection: 40,120,40 with width 1 < alpha2 -> no candidate and no count change.
REQ-036 SHALL verify too-fast rejection: while walking, next candidate at interval 2 -> step_count unchanged and no step_pulse.
REQ-037 SHALL verify timeout: while walking, 21 samples of 40 -> walking=0; next valid peak gives run=1 and no count change.
REQ-038 SHALL verify clear priority: clear_count asserted on an accepting sample -> step_count=0, walking=0, no wb_valid.
